// File: rtl/rx_ts_queue_ctrl_if.sv
// Signal bundle between the rx frame parser / TSU register block and rx_ts_queue_ctrl.
// master drives the parser and CPU-side controls; slave is the queue controller.
interface rx_ts_queue_ctrl_if #(
    parameter int AW = 2
) ();
    logic          enable_i;
    logic [15:0]   msgtype_mask_i;
    logic [AW:0]   int_thresh_i;
    logic          rxts_trig_i;
    logic          rxts_valid_i;
    logic [95:0]   sfd_ts_i;
    logic [3:0]    msgtype_i;
    logic [15:0]   seqid_i;
    logic [79:0]   src_port_id_i;
    logic          pop_i;
    logic          clr_i;
    logic          head_valid_o;
    logic [95:0]   head_ts_o;
    logic [3:0]    head_msgtype_o;
    logic [15:0]   head_seqid_o;
    logic [79:0]   head_src_port_id_o;
    logic [AW:0]   count_o;
    logic          ovf_o;
    logic [7:0]    drop_cnt_o;
    logic          int_o;

    modport master (
        output enable_i, msgtype_mask_i, int_thresh_i, rxts_trig_i, rxts_valid_i,
               sfd_ts_i, msgtype_i, seqid_i, src_port_id_i, pop_i, clr_i,
        input  head_valid_o, head_ts_o, head_msgtype_o, head_seqid_o,
               head_src_port_id_o, count_o, ovf_o, drop_cnt_o, int_o
    );

    modport slave (
        input  enable_i, msgtype_mask_i, int_thresh_i, rxts_trig_i, rxts_valid_i,
               sfd_ts_i, msgtype_i, seqid_i, src_port_id_i, pop_i, clr_i,
        output head_valid_o, head_ts_o, head_msgtype_o, head_seqid_o,
               head_src_port_id_o, count_o, ovf_o, drop_cnt_o, int_o
    );
endinterface

// File: rtl/rx_ts_queue_ctrl.sv
// Receive timestamp controller: pairs SFD trig with header valid, queues committed
// PTP events for the CPU side, tracks lost events and drives the rx PTP interrupt.
module rx_ts_queue_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int TMO   = 64
) (
    input logic               rx_clk,
    input logic               rx_rst_n,
    rx_ts_queue_ctrl_if.slave bus
);
    localparam int CW = $clog2(TMO);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   tmo_q, tmo_d;
    logic [95:0]     ts_q, ts_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_q, drop_d;
    logic            int_q, int_d;
    logic            commit, drop_arm, pop_eff, full, push, lost;

    logic [95:0]     ts_mem  [DEPTH];
    logic [3:0]      mt_mem  [DEPTH];
    logic [15:0]     seq_mem [DEPTH];
    logic [79:0]     src_mem [DEPTH];

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        ts_d     = ts_q;
        commit   = 1'b0;
        drop_arm = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable_i && bus.rxts_trig_i) begin
                    ts_d    = bus.sfd_ts_i;
                    tmo_d   = '0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!bus.enable_i) begin
                    state_d = IDLE;
                end else if (bus.rxts_valid_i) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (bus.rxts_trig_i) begin
                    ts_d     = bus.sfd_ts_i;
                    tmo_d    = '0;
                    drop_arm = 1'b1;
                end else if (tmo_q == CW'(TMO - 1)) begin
                    state_d  = IDLE;
                    drop_arm = 1'b1;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.clr_i) state_d = IDLE;
    end

    // A full queue still accepts a commit when the head is popped on the same edge.
    assign pop_eff = bus.pop_i && (count_q != '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign push    = commit && bus.msgtype_mask_i[bus.msgtype_i] && (!full || pop_eff);
    assign lost    = commit && bus.msgtype_mask_i[bus.msgtype_i] && full && !pop_eff;

    always_comb begin
        wptr_d  = push    ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop_eff ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop_eff)      count_d = count_q + (AW+1)'(1);
        else if (pop_eff && !push) count_d = count_q - (AW+1)'(1);
        ovf_d  = ovf_q | lost;
        drop_d = drop_q;
        if ((drop_arm || lost) && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (bus.clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end
        int_d = ovf_d || ((bus.int_thresh_i != '0) && (count_d >= bus.int_thresh_i));
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            ts_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            ts_q    <= ts_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            int_q   <= int_d;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (push && !bus.clr_i) begin
            ts_mem[wptr_q]  <= ts_q;
            mt_mem[wptr_q]  <= bus.msgtype_i;
            seq_mem[wptr_q] <= bus.seqid_i;
            src_mem[wptr_q] <= bus.src_port_id_i;
        end
    end

    // Head fields are forced to zero when empty so reset leaves every output at 0.
    assign bus.head_valid_o       = (count_q != '0);
    assign bus.head_ts_o          = bus.head_valid_o ? ts_mem[rptr_q]  : '0;
    assign bus.head_msgtype_o     = bus.head_valid_o ? mt_mem[rptr_q]  : '0;
    assign bus.head_seqid_o       = bus.head_valid_o ? seq_mem[rptr_q] : '0;
    assign bus.head_src_port_id_o = bus.head_valid_o ? src_mem[rptr_q] : '0;
    assign bus.count_o            = count_q;
    assign bus.ovf_o              = ovf_q;
    assign bus.drop_cnt_o         = drop_q;
    assign bus.int_o              = int_q;
endmodule

// File: tb/tb_rx_ts_queue_ctrl.sv
// Directed bench for rx_ts_queue_ctrl with a queue-level reference model checked every cycle.
module tb_rx_ts_queue_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int TMO   = 64;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rx_ts_queue_ctrl_if #(.AW(AW)) bus ();

    rx_ts_queue_ctrl #(.DEPTH(DEPTH), .AW(AW), .TMO(TMO)) dut (
        .rx_clk  (clk),
        .rx_rst_n(rst_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [95:0] ts;
        logic [3:0]  mt;
        logic [15:0] seq;
        logic [79:0] src;
    } ent_t;

    ent_t        mq[$];
    bit          m_armed;
    int          m_waited;
    logic [95:0] m_lat;
    int          m_drops;
    bit          m_ovf;
    bit          m_int;

    function automatic void bump();
        if (m_drops < 255) m_drops++;
    endfunction

    // Reference model: event-level view of the trig/valid pairing and the queue.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_armed = 0; m_waited = 0; m_lat = '0; m_drops = 0; m_ovf = 0;
        end else if (bus.clr_i) begin
            mq.delete();
            m_armed = 0; m_drops = 0; m_ovf = 0;
        end else begin
            automatic bit do_commit = 0;
            automatic bit popok = bus.pop_i && (mq.size() > 0);
            if (m_armed) begin
                m_waited++;
                if (!bus.enable_i) m_armed = 0;
                else if (bus.rxts_valid_i) begin do_commit = 1; m_armed = 0; end
                else if (bus.rxts_trig_i) begin m_lat = bus.sfd_ts_i; m_waited = 0; bump(); end
                else if (m_waited == TMO) begin m_armed = 0; bump(); end
            end else if (bus.enable_i && bus.rxts_trig_i) begin
                m_armed = 1; m_lat = bus.sfd_ts_i; m_waited = 0;
            end
            if (popok) mq.delete(0);
            if (do_commit && bus.msgtype_mask_i[bus.msgtype_i]) begin
                if (mq.size() == DEPTH) begin m_ovf = 1; bump(); end
                else mq.push_back('{m_lat, bus.msgtype_i, bus.seqid_i, bus.src_port_id_i});
            end
        end
        m_int = rst_n && (m_ovf || (bus.int_thresh_i != 0 && mq.size() >= int'(bus.int_thresh_i)));
        #1;
        chk("head_valid", 128'(bus.head_valid_o), 128'(mq.size() != 0));
        chk("count", 128'(bus.count_o), 128'(mq.size()));
        if (mq.size() != 0) begin
            chk("head_ts", 128'(bus.head_ts_o), 128'(mq[0].ts));
            chk("head_msgtype", 128'(bus.head_msgtype_o), 128'(mq[0].mt));
            chk("head_seqid", 128'(bus.head_seqid_o), 128'(mq[0].seq));
            chk("head_src", 128'(bus.head_src_port_id_o), 128'(mq[0].src));
        end
        chk("ovf", 128'(bus.ovf_o), 128'(m_ovf));
        chk("drop_cnt", 128'(bus.drop_cnt_o), 128'(m_drops));
        chk("int", 128'(bus.int_o), 128'(m_int));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_trig(input logic [95:0] ts);
        bus.rxts_trig_i = 1'b1; bus.sfd_ts_i = ts;
        @(negedge clk);
        bus.rxts_trig_i = 1'b0;
    endtask

    task automatic pulse_valid(input logic [3:0] mt, input logic [15:0] seq, input logic [79:0] src);
        bus.rxts_valid_i = 1'b1; bus.msgtype_i = mt; bus.seqid_i = seq; bus.src_port_id_i = src;
        @(negedge clk);
        bus.rxts_valid_i = 1'b0;
    endtask

    task automatic send(input logic [95:0] ts, input logic [3:0] mt, input logic [15:0] seq);
        pulse_trig(ts);
        idle(2);
        pulse_valid(mt, seq, 80'hA000 + 80'(seq));
    endtask

    task automatic do_pop();
        bus.pop_i = 1'b1;
        @(negedge clk);
        bus.pop_i = 1'b0;
    endtask

    task automatic do_clr();
        bus.clr_i = 1'b1;
        @(negedge clk);
        bus.clr_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable_i = 1'b1; bus.msgtype_mask_i = 16'h0001; bus.int_thresh_i = '0;
        bus.rxts_trig_i = 1'b0; bus.rxts_valid_i = 1'b0; bus.sfd_ts_i = '0;
        bus.msgtype_i = '0; bus.seqid_i = '0; bus.src_port_id_i = '0;
        bus.pop_i = 1'b0; bus.clr_i = 1'b0;
        idle(3);
        chk("rst head_valid", 128'(bus.head_valid_o), 128'(0));
        chk("rst count", 128'(bus.count_o), 128'(0));
        chk("rst int", 128'(bus.int_o), 128'(0));
        rst_n = 1'b1;
        idle(2);

        // 1: single event, head visible the cycle after valid
        send(96'h0000_0000_1234_DEAD_BEEF_0042, 4'd0, 16'd7);
        chk("t1 head_valid", 128'(bus.head_valid_o), 128'(1));
        chk("t1 count", 128'(bus.count_o), 128'(1));
        chk("t1 head_ts", 128'(bus.head_ts_o), 128'(96'h0000_0000_1234_DEAD_BEEF_0042));

        // 2: overflow, then simultaneous pop+push while full
        do_clr();
        for (int i = 0; i < 5; i++) send(96'h100 + 96'(i), 4'd0, 16'(i));
        chk("t2 count", 128'(bus.count_o), 128'(4));
        chk("t2 ovf", 128'(bus.ovf_o), 128'(1));
        chk("t2 drop", 128'(bus.drop_cnt_o), 128'(1));
        chk("t2 int", 128'(bus.int_o), 128'(1));
        pulse_trig(96'h200);
        idle(2);
        bus.pop_i = 1'b1;
        pulse_valid(4'd0, 16'd9, 80'hA009);
        bus.pop_i = 1'b0;
        chk("t2 full pop+push count", 128'(bus.count_o), 128'(4));
        chk("t2 full pop+push head", 128'(bus.head_seqid_o), 128'(1));
        chk("t2 full pop+push drop", 128'(bus.drop_cnt_o), 128'(1));

        // 3: timeout exactly TMO cycles after trig; late valid ignored
        do_clr();
        pulse_trig(96'h300);
        idle(TMO - 1);
        chk("t3 drop before tmo", 128'(bus.drop_cnt_o), 128'(0));
        idle(1);
        chk("t3 drop at tmo", 128'(bus.drop_cnt_o), 128'(1));
        pulse_valid(4'd0, 16'd3, 80'hA003);
        chk("t3 late valid count", 128'(bus.count_o), 128'(0));
        chk("t3 late valid drop", 128'(bus.drop_cnt_o), 128'(1));

        // 4: re-trig overrides the timestamp
        do_clr();
        pulse_trig(96'h400);
        idle(4);
        pulse_trig(96'h401);
        idle(2);
        pulse_valid(4'd0, 16'd4, 80'hA004);
        chk("t4 count", 128'(bus.count_o), 128'(1));
        chk("t4 head_ts", 128'(bus.head_ts_o), 128'(96'h401));
        chk("t4 drop", 128'(bus.drop_cnt_o), 128'(1));

        // 5: masked type, then fill-threshold interrupt
        do_clr();
        send(96'h500, 4'd8, 16'd5);
        chk("t5 masked count", 128'(bus.count_o), 128'(0));
        chk("t5 masked drop", 128'(bus.drop_cnt_o), 128'(0));
        bus.int_thresh_i = 3'd2;
        send(96'h501, 4'd0, 16'd51);
        chk("t5 int after 1", 128'(bus.int_o), 128'(0));
        send(96'h502, 4'd0, 16'd52);
        chk("t5 int after 2", 128'(bus.int_o), 128'(1));
        do_pop();
        chk("t5 int after pop", 128'(bus.int_o), 128'(0));
        chk("t5 head after pop", 128'(bus.head_seqid_o), 128'(52));
        bus.int_thresh_i = '0;

        // 6: drop counter saturation, clr beats valid, async reset while armed
        do_clr();
        for (int i = 0; i < 260; i++) begin
            pulse_trig(96'h600);
            idle(TMO);
        end
        chk("t6 drop sat", 128'(bus.drop_cnt_o), 128'(255));
        send(96'h601, 4'd0, 16'd61);
        pulse_trig(96'h602);
        idle(2);
        bus.clr_i = 1'b1;
        pulse_valid(4'd0, 16'd62, 80'hA062);
        bus.clr_i = 1'b0;
        chk("t6 clr count", 128'(bus.count_o), 128'(0));
        chk("t6 clr head_valid", 128'(bus.head_valid_o), 128'(0));
        chk("t6 clr drop", 128'(bus.drop_cnt_o), 128'(0));
        chk("t6 clr ovf", 128'(bus.ovf_o), 128'(0));
        send(96'h603, 4'd0, 16'd63);
        pulse_trig(96'h604);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst head_valid", 128'(bus.head_valid_o), 128'(0));
        chk("t6 rst count", 128'(bus.count_o), 128'(0));
        chk("t6 rst head_seqid", 128'(bus.head_seqid_o), 128'(0));
        idle(2);
        rst_n = 1'b1;
        pulse_valid(4'd0, 16'd64, 80'hA064);
        chk("t6 valid after rst", 128'(bus.count_o), 128'(0));
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
